// File: rtl/vex_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vex_bus_arbiter
//  Description : Merges the VexRiscv iBus and dBus command channels into one
//                registered request stream toward the L1.5 transducer, with
//                a single outstanding request, and steers the response back
//                to the bus that issued it.
//  Revision    : 1.0 - initial release
// ============================================================================
module vex_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_ARB     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // iBus
    input  logic                  ibus_cmd_valid,
    input  logic [ADDR_WIDTH-1:0] ibus_cmd_pc,
    output logic                  ibus_cmd_ready,
    output logic                  ibus_rsp_valid,
    output logic [DATA_WIDTH-1:0] ibus_rsp_inst,
    // dBus
    input  logic                  dbus_cmd_valid,
    input  logic                  dbus_cmd_wr,
    input  logic [ADDR_WIDTH-1:0] dbus_cmd_address,
    input  logic [DATA_WIDTH-1:0] dbus_cmd_data,
    input  logic [1:0]            dbus_cmd_size,
    output logic                  dbus_cmd_ready,
    output logic                  dbus_rsp_valid,
    output logic [DATA_WIDTH-1:0] dbus_rsp_data,
    // transducer side
    output logic                  arb_req_val,
    output logic                  arb_req_is_data,
    output logic                  arb_req_wr,
    output logic [ADDR_WIDTH-1:0] arb_req_addr,
    output logic [DATA_WIDTH-1:0] arb_req_data,
    output logic [1:0]            arb_req_size,
    input  logic                  arb_req_ack,
    input  logic                  arb_rsp_val,
    input  logic [DATA_WIDTH-1:0] arb_rsp_data,
    output logic                  arb_spurious_rsp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_dbus_q;   // 0 = iBus was granted last
    logic                   owner_is_data_q;
    logic                   req_wr_q;
    logic [ADDR_WIDTH-1:0]  req_addr_q;
    logic [DATA_WIDTH-1:0]  req_data_q;
    logic [1:0]             req_size_q;
    logic                   ibus_rsp_valid_q;
    logic [DATA_WIDTH-1:0]  ibus_rsp_inst_q;
    logic                   dbus_rsp_valid_q;
    logic [DATA_WIDTH-1:0]  dbus_rsp_data_q;
    logic                   spurious_q;

    logic                   take;        // a command is captured this cycle
    logic                   grant_dbus;  // winner of this cycle's arbitration
    logic                   complete;    // outstanding request finishes this cycle

    // Arbitration: only meaningful in IDLE; round-robin alternates on a tie,
    // fixed priority lets the dBus win a tie.
    always_comb begin
        grant_dbus = dbus_cmd_valid;
        if (ibus_cmd_valid && dbus_cmd_valid) begin
            grant_dbus = (RR_ARB != 0) ? ~last_grant_dbus_q : 1'b1;
        end
        take           = (state_q == S_IDLE) && (ibus_cmd_valid || dbus_cmd_valid);
        // Gated with rst_n so the handshake reads 0 while the block is held in reset.
        ibus_cmd_ready = take && !grant_dbus && rst_n;
        dbus_cmd_ready = take &&  grant_dbus && rst_n;
    end

    // Next-state logic; a response in REQ counts as ack plus response.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take) state_d = S_REQ;
            end
            S_REQ: begin
                if (arb_rsp_val) begin
                    state_d  = S_IDLE;
                    complete = 1'b1;
                end else if (arb_req_ack) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (arb_rsp_val) begin
                    state_d  = S_IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Capture the winning command; fields stay frozen until the next capture.
    // An instruction fetch is always a full word with no store data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_dbus_q <= 1'b0;
            owner_is_data_q   <= 1'b0;
            req_wr_q          <= 1'b0;
            req_addr_q        <= '0;
            req_data_q        <= '0;
            req_size_q        <= 2'd0;
        end else if (take) begin
            last_grant_dbus_q <= grant_dbus;
            owner_is_data_q   <= grant_dbus;
            req_wr_q          <= grant_dbus & dbus_cmd_wr;
            req_addr_q        <= grant_dbus ? dbus_cmd_address : ibus_cmd_pc;
            req_data_q        <= grant_dbus ? dbus_cmd_data : '0;
            req_size_q        <= grant_dbus ? dbus_cmd_size : 2'd2;
        end
    end

    // Route the response to its owner one cycle later; store acks are absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibus_rsp_valid_q <= 1'b0;
            ibus_rsp_inst_q  <= '0;
            dbus_rsp_valid_q <= 1'b0;
            dbus_rsp_data_q  <= '0;
            spurious_q       <= 1'b0;
        end else begin
            ibus_rsp_valid_q <= complete && !owner_is_data_q;
            dbus_rsp_valid_q <= complete && owner_is_data_q && !req_wr_q;
            spurious_q       <= arb_rsp_val && (state_q == S_IDLE);
            if (complete && !owner_is_data_q) ibus_rsp_inst_q <= arb_rsp_data;
            if (complete && owner_is_data_q && !req_wr_q) dbus_rsp_data_q <= arb_rsp_data;
        end
    end

    assign arb_req_val      = (state_q == S_REQ);
    assign arb_req_is_data  = owner_is_data_q;
    assign arb_req_wr       = req_wr_q;
    assign arb_req_addr     = req_addr_q;
    assign arb_req_data     = req_data_q;
    assign arb_req_size     = req_size_q;
    assign ibus_rsp_valid   = ibus_rsp_valid_q;
    assign ibus_rsp_inst    = ibus_rsp_inst_q;
    assign dbus_rsp_valid   = dbus_rsp_valid_q;
    assign dbus_rsp_data    = dbus_rsp_data_q;
    assign arb_spurious_rsp = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_vex_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vex_bus_arbiter
//  Description : Self-checking bench for vex_bus_arbiter: directed scenarios
//                with literal expectations, then randomized traffic compared
//                every cycle against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vex_bus_arbiter;

    localparam int RR = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_cmd_valid;
    logic [31:0] ibus_cmd_pc;
    logic        ibus_cmd_ready;
    logic        ibus_rsp_valid;
    logic [31:0] ibus_rsp_inst;
    logic        dbus_cmd_valid;
    logic        dbus_cmd_wr;
    logic [31:0] dbus_cmd_address;
    logic [31:0] dbus_cmd_data;
    logic [1:0]  dbus_cmd_size;
    logic        dbus_cmd_ready;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rsp_data;
    logic        arb_req_val;
    logic        arb_req_is_data;
    logic        arb_req_wr;
    logic [31:0] arb_req_addr;
    logic [31:0] arb_req_data;
    logic [1:0]  arb_req_size;
    logic        arb_req_ack;
    logic        arb_rsp_val;
    logic [31:0] arb_rsp_data;
    logic        arb_spurious_rsp;

    always #5 clk = ~clk;

    vex_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_ARB(RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_pc(ibus_cmd_pc),
        .ibus_cmd_ready(ibus_cmd_ready), .ibus_rsp_valid(ibus_rsp_valid),
        .ibus_rsp_inst(ibus_rsp_inst),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_wr(dbus_cmd_wr),
        .dbus_cmd_address(dbus_cmd_address), .dbus_cmd_data(dbus_cmd_data),
        .dbus_cmd_size(dbus_cmd_size), .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_data(dbus_rsp_data),
        .arb_req_val(arb_req_val), .arb_req_is_data(arb_req_is_data),
        .arb_req_wr(arb_req_wr), .arb_req_addr(arb_req_addr),
        .arb_req_data(arb_req_data), .arb_req_size(arb_req_size),
        .arb_req_ack(arb_req_ack), .arb_rsp_val(arb_rsp_val),
        .arb_rsp_data(arb_rsp_data), .arb_spurious_rsp(arb_spurious_rsp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a queue holds the outstanding request (at
    // most one); 'accepted' records that the transducer has taken it.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        is_data;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } req_t;

    req_t        pend[$];
    req_t        m_cur;          // most recently captured request
    bit          accepted;
    bit          m_last_dbus;
    bit          m_iv, m_dv, m_spur;
    logic [31:0] m_inst, m_ddata;
    bit          want_d, any_cmd, idle;
    req_t        fin, nreq;

    // Compare DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ctrl", {ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid, dbus_rsp_valid,
                               arb_req_val, arb_req_is_data, arb_req_wr, arb_spurious_rsp, arb_req_size}, 0);
            check("rst_addr", arb_req_addr, 0);
            check("rst_data", arb_req_data, 0);
            check("rst_inst", ibus_rsp_inst, 0);
            check("rst_drsp", dbus_rsp_data, 0);
            pend.delete();
            m_cur = '0; accepted = 0; m_last_dbus = 0;
            m_iv = 0; m_dv = 0; m_spur = 0; m_inst = 0; m_ddata = 0;
        end else begin
            idle    = (pend.size() == 0);
            any_cmd = ibus_cmd_valid || dbus_cmd_valid;
            if (ibus_cmd_valid && dbus_cmd_valid) want_d = (RR != 0) ? !m_last_dbus : 1'b1;
            else                                  want_d = dbus_cmd_valid;

            check("ibus_cmd_ready", ibus_cmd_ready, idle && any_cmd && !want_d);
            check("dbus_cmd_ready", dbus_cmd_ready, idle && any_cmd && want_d);
            check("arb_req_val", arb_req_val, !idle && !accepted);
            check("arb_req_ctrl", {arb_req_is_data, arb_req_wr, arb_req_size}, {m_cur.is_data, m_cur.wr, m_cur.size});
            check("arb_req_addr", arb_req_addr, m_cur.addr);
            check("arb_req_data", arb_req_data, m_cur.data);
            check("rsp_valids", {ibus_rsp_valid, dbus_rsp_valid, arb_spurious_rsp}, {m_iv, m_dv, m_spur});
            check("ibus_rsp_inst", ibus_rsp_inst, m_inst);
            check("dbus_rsp_data", dbus_rsp_data, m_ddata);

            m_iv = 0; m_dv = 0;
            m_spur = arb_rsp_val && idle;
            if (!idle) begin
                if (arb_rsp_val) begin
                    fin = pend.pop_front();
                    accepted = 0;
                    if (!fin.is_data) begin m_iv = 1; m_inst = arb_rsp_data; end
                    else if (!fin.wr) begin m_dv = 1; m_ddata = arb_rsp_data; end
                end else if (arb_req_ack) begin
                    accepted = 1;
                end
            end else if (any_cmd) begin
                if (want_d) nreq = '{1'b1, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size};
                else        nreq = '{1'b0, 1'b0, ibus_cmd_pc, 32'h0, 2'd2};
                pend.push_back(nreq);
                m_cur = nreq;
                accepted = 0;
                m_last_dbus = want_d;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        ibus_cmd_valid = 0; ibus_cmd_pc = 0;
        dbus_cmd_valid = 0; dbus_cmd_wr = 0; dbus_cmd_address = 0; dbus_cmd_data = 0; dbus_cmd_size = 0;
        arb_req_ack = 0; arb_rsp_val = 0; arb_rsp_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_val", arb_req_val, 0);
        check("reset_rsp", {ibus_rsp_valid, dbus_rsp_valid, arb_spurious_rsp}, 0);
        rst_n = 1;

        // 1. iBus fetch, ack at t+2, response at t+4
        step(); ibus_cmd_valid = 1; ibus_cmd_pc = 32'h8000_0000; #1;
        check("t1_ibus_ready", ibus_cmd_ready, 1);
        check("t1_dbus_ready", dbus_cmd_ready, 0);
        step(); ibus_cmd_valid = 0; #1;
        check("t1_req_val", arb_req_val, 1);
        check("t1_is_data", arb_req_is_data, 0);
        check("t1_addr", arb_req_addr, 32'h8000_0000);
        step(); arb_req_ack = 1;
        step(); arb_req_ack = 0; #1;
        check("t1_wait_req_val", arb_req_val, 0);
        step(); arb_rsp_val = 1; arb_rsp_data = 32'h0000_0013;
        step(); arb_rsp_val = 0; #1;
        check("t1_rsp_valid", ibus_rsp_valid, 1);
        check("t1_inst", ibus_rsp_inst, 32'h0000_0013);
        step(); #1;
        check("t1_rsp_pulse_end", ibus_rsp_valid, 0);
        check("t1_inst_hold", ibus_rsp_inst, 32'h0000_0013);

        // 2. Simultaneous requests, last grant was iBus -> dBus first
        ibus_cmd_valid = 1; ibus_cmd_pc = 32'h8000_0004;
        dbus_cmd_valid = 1; dbus_cmd_wr = 0; dbus_cmd_address = 32'h100; dbus_cmd_size = 2; #1;
        check("t2_dbus_ready", dbus_cmd_ready, 1);
        check("t2_ibus_ready", ibus_cmd_ready, 0);
        step(); dbus_cmd_valid = 0; #1;
        check("t2_ibus_ignored", ibus_cmd_ready, 0);
        check("t2_is_data", arb_req_is_data, 1);
        check("t2_addr", arb_req_addr, 32'h100);
        step(); arb_req_ack = 1; arb_rsp_val = 1; arb_rsp_data = 32'h0000_0055;
        step(); arb_req_ack = 0; arb_rsp_val = 0; #1;
        check("t2_ibus_next_idle", ibus_cmd_ready, 1);
        check("t2_drsp_valid", dbus_rsp_valid, 1);
        check("t2_drsp_data", dbus_rsp_data, 32'h0000_0055);
        step(); ibus_cmd_valid = 0; arb_req_ack = 1; #1;
        check("t2_ibus_addr", arb_req_addr, 32'h8000_0004);
        step(); arb_req_ack = 0; arb_rsp_val = 1; arb_rsp_data = 32'h0000_0093;
        step(); arb_rsp_val = 0; #1;
        check("t2_inst", ibus_rsp_inst, 32'h0000_0093);

        // 3. Store, fields scrambled after capture, ack delayed
        dbus_cmd_valid = 1; dbus_cmd_wr = 1; dbus_cmd_address = 32'h200;
        dbus_cmd_data = 32'hDEAD_BEEF; dbus_cmd_size = 2; #1;
        check("t3_dbus_ready", dbus_cmd_ready, 1);
        step(); dbus_cmd_valid = 0; dbus_cmd_wr = 0; dbus_cmd_address = 32'hFFFF_FFFF;
        dbus_cmd_data = 0; dbus_cmd_size = 0; #1;
        check("t3_wr", arb_req_wr, 1);
        check("t3_addr", arb_req_addr, 32'h200);
        check("t3_size", arb_req_size, 2);
        step(); #1;
        check("t3_data_held", arb_req_data, 32'hDEAD_BEEF);
        step(); arb_req_ack = 1;
        step(); arb_req_ack = 0; arb_rsp_val = 1; arb_rsp_data = 32'h1234_5678;
        step(); arb_rsp_val = 0; #1;
        check("t3_no_drsp", dbus_rsp_valid, 0);
        check("t3_drsp_hold", dbus_rsp_data, 32'h0000_0055);

        // 4. Back in IDLE: load with ack and response together
        dbus_cmd_valid = 1; dbus_cmd_wr = 0; dbus_cmd_address = 32'h300; dbus_cmd_size = 2; #1;
        check("t4_dbus_ready", dbus_cmd_ready, 1);
        step(); dbus_cmd_valid = 0; arb_req_ack = 1; arb_rsp_val = 1; arb_rsp_data = 32'hCAFE_F00D;
        step(); arb_req_ack = 0; arb_rsp_val = 0; #1;
        check("t4_drsp_valid", dbus_rsp_valid, 1);
        check("t4_drsp_data", dbus_rsp_data, 32'hCAFE_F00D);
        check("t4_req_val", arb_req_val, 0);

        // 5. Response with nothing outstanding
        step(); arb_rsp_val = 1; arb_rsp_data = 32'h0000_AAAA;
        step(); arb_rsp_val = 0; #1;
        check("t5_spurious", arb_spurious_rsp, 1);
        check("t5_no_rsp", {ibus_rsp_valid, dbus_rsp_valid}, 0);
        step(); #1;
        check("t5_spurious_end", arb_spurious_rsp, 0);

        // 6. Reset while waiting for the response
        ibus_cmd_valid = 1; ibus_cmd_pc = 32'h8000_0010; #1;
        check("t6_ibus_ready", ibus_cmd_ready, 1);
        step(); ibus_cmd_valid = 0; arb_req_ack = 1;
        step(); arb_req_ack = 0; #1;
        check("t6_wait", arb_req_val, 0);
        ibus_cmd_valid = 1; ibus_cmd_pc = 32'h8000_0100; #1;
        check("t6_ignored_in_wait", ibus_cmd_ready, 0);
        rst_n = 0; #1;
        check("t6_async_ctrl", {ibus_cmd_ready, arb_req_is_data, arb_req_size, ibus_rsp_valid}, 0);
        check("t6_async_addr", arb_req_addr, 0);
        check("t6_async_inst", ibus_rsp_inst, 0);
        step(); step(); rst_n = 1; #1;
        check("t6_recapture", ibus_cmd_ready, 1);
        step(); ibus_cmd_valid = 0; #1;
        check("t6_req_val", arb_req_val, 1);
        check("t6_addr", arb_req_addr, 32'h8000_0100);
        step(); arb_req_ack = 1;
        step(); arb_req_ack = 0; arb_rsp_val = 1; arb_rsp_data = 32'h0000_0013;
        step(); arb_rsp_val = 0;

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            step();
            ibus_cmd_valid   = ($urandom_range(0, 2) != 0);
            ibus_cmd_pc      = $urandom;
            dbus_cmd_valid   = ($urandom_range(0, 2) != 0);
            dbus_cmd_wr      = $urandom_range(0, 1);
            dbus_cmd_address = $urandom;
            dbus_cmd_data    = $urandom;
            dbus_cmd_size    = 2'($urandom_range(0, 2));
            arb_req_ack      = ($urandom_range(0, 2) == 0);
            arb_rsp_val      = ($urandom_range(0, 3) == 0);
            arb_rsp_data     = $urandom;
        end
        step();
        ibus_cmd_valid = 0; dbus_cmd_valid = 0; arb_req_ack = 0; arb_rsp_val = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
